// File: rtl/packet_queue.sv
// Receive-side packet FIFO between flit reassembly and the message stage.
// Upstream sees a combinational grant; downstream sees the oldest packet straight from storage.
module packet_queue #(
  parameter int PKT_WIDTH  = 128,
  parameter int N_PACKETS  = 4,
  parameter int N_BITS_PTR = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r_pkt_to_msg_i,
  input  logic [PKT_WIDTH-1:0]  in_pkt_i,
  output logic                  g_pkt_to_msg_o,
  output logic                  msg_valid_o,
  output logic [PKT_WIDTH-1:0]  out_msg_o,
  input  logic                  msg_ack_i,
  output logic [N_BITS_PTR:0]   count_o,
  output logic                  full_o
);

  localparam logic [N_BITS_PTR:0] FULL_CNT = (N_BITS_PTR+1)'(N_PACKETS);

  logic [PKT_WIDTH-1:0]  r_mem [N_PACKETS];
  logic [N_BITS_PTR-1:0] r_wr_ptr;
  logic [N_BITS_PTR-1:0] r_rd_ptr;
  logic [N_BITS_PTR:0]   r_cnt;
  logic                  w_push;
  logic                  w_pop;

  // Grant ignores msg_ack_i: a pop never makes room for a push in the same cycle.
  assign full_o         = (r_cnt == FULL_CNT);
  assign g_pkt_to_msg_o = r_pkt_to_msg_i & ~full_o & ~rst;
  assign msg_valid_o    = (r_cnt != '0);
  assign out_msg_o      = r_mem[r_rd_ptr];
  assign count_o        = r_cnt;

  assign w_push = r_pkt_to_msg_i & g_pkt_to_msg_o;
  assign w_pop  = msg_valid_o & msg_ack_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Packet storage carries no reset; w_push already excludes reset cycles.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_pkt_i;
  end

endmodule

// File: tb/tb_packet_queue.sv
// Self-checking bench for packet_queue against a queue-based reference model.
module tb_packet_queue;
  localparam int W = 128;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         r   = 1'b0;
  logic         ack = 1'b0;
  logic [W-1:0] pin = '0;
  logic         g, vld, full;
  logic [W-1:0] pout;
  logic [2:0]   cnt;

  logic [W-1:0] mq[$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  packet_queue #(.PKT_WIDTH(W), .N_PACKETS(N), .N_BITS_PTR(2)) dut (
    .clk(clk), .rst(rst), .r_pkt_to_msg_i(r), .in_pkt_i(pin),
    .g_pkt_to_msg_o(g), .msg_valid_o(vld), .out_msg_o(pout),
    .msg_ack_i(ack), .count_o(cnt), .full_o(full)
  );

  function automatic logic [W-1:0] rnd_pkt();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Advance one clock, applying the queue rules to the model.
  task automatic tick();
    bit push, pop;
    push = !rst && r && (mq.size() < N);
    pop  = !rst && ack && (mq.size() > 0);
    @(posedge clk);
    if (rst) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(pin);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; r = 1'b1; ack = 1'b0; pin = rnd_pkt();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (g !== 1'b0) begin n_err++; $display("FAIL reset_grant cyc%0d: got %b want 0", i, g); end
      tick();
    end
    rst = 1'b0; r = 1'b0; #1;
    n_vec++; if (vld !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", vld); end
    n_vec++; if (cnt !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", cnt); end
    n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", full); end
    r = 1'b1; #1;
    n_vec++; if (g !== 1'b1) begin n_err++; $display("FAIL grant_after_reset: got %b want 1", g); end
    r = 1'b0; #1;
  endtask

  task automatic test_single();
    logic [W-1:0] p;
    p = 128'h0000_0004_0000_0003_0000_0002_0000_0001;
    r = 1'b1; pin = p; #1;
    n_vec++; if (g !== 1'b1) begin n_err++; $display("FAIL single_grant: got %b want 1", g); end
    tick(); r = 1'b0; pin = rnd_pkt();
    n_vec++; if (vld !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", vld); end
    n_vec++; if (pout !== p) begin n_err++; $display("FAIL single_data: got %h want %h", pout, p); end
    n_vec++; if (cnt !== 3'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", cnt); end
    ack = 1'b1; tick(); ack = 1'b0;
    n_vec++; if (vld !== 1'b0) begin n_err++; $display("FAIL single_valid_after_ack: got %b want 0", vld); end
    n_vec++; if (cnt !== 3'd0) begin n_err++; $display("FAIL single_count_after_ack: got %0d want 0", cnt); end
  endtask

  task automatic test_fill();
    r = 1'b1;
    for (int v = 1; v <= 4; v++) begin pin = W'(v); tick(); end
    r = 1'b0; #1;
    n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL fill_full: got %b want 1", full); end
    n_vec++; if (cnt !== 3'd4) begin n_err++; $display("FAIL fill_count: got %0d want 4", cnt); end
    r = 1'b1; pin = W'(5);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (g !== 1'b0) begin n_err++; $display("FAIL fill_hold_grant cyc%0d: got %b want 0", i, g); end
      tick();
    end
    ack = 1'b1; #1;
    n_vec++; if (g !== 1'b0) begin n_err++; $display("FAIL full_ack_grant: got %b want 0", g); end
    tick(); ack = 1'b0;
    n_vec++; if (pout !== W'(2)) begin n_err++; $display("FAIL fill_release_data: got %0d want 2", pout); end
    n_vec++; if (g !== 1'b1) begin n_err++; $display("FAIL fill_release_grant: got %b want 1", g); end
    n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL fill_release_full: got %b want 0", full); end
    tick(); r = 1'b0;
    n_vec++; if (cnt !== 3'd4) begin n_err++; $display("FAIL fill_fifth_count: got %0d want 4", cnt); end
    ack = 1'b1;
    for (int v = 2; v <= 5; v++) begin
      n_vec++; if (pout !== W'(v)) begin n_err++; $display("FAIL fill_drain_data: got %0d want %0d", pout, v); end
      tick();
    end
    ack = 1'b0;
    n_vec++; if (cnt !== 3'd0) begin n_err++; $display("FAIL fill_drain_count: got %0d want 0", cnt); end
  endtask

  task automatic test_wrap();
    int nxt = 1;
    int got = 0;
    int cyc = 0;
    while (got < 10 && cyc < 300) begin
      r = (nxt <= 10) && ($urandom_range(3) != 0);
      pin = W'(nxt);
      ack = ($urandom_range(1) == 1);
      #1;
      n_vec++; if (g !== (r && mq.size() < N)) begin n_err++; $display("FAIL wrap_grant cyc%0d: got %b want %b", cyc, g, r && mq.size() < N); end
      n_vec++; if (cnt !== 3'(mq.size()) || cnt > 3'd4) begin n_err++; $display("FAIL wrap_count cyc%0d: got %0d want %0d", cyc, cnt, mq.size()); end
      n_vec++; if (vld !== (mq.size() != 0)) begin n_err++; $display("FAIL wrap_valid cyc%0d: got %b want %b", cyc, vld, mq.size() != 0); end
      n_vec++; if (full !== (mq.size() == N)) begin n_err++; $display("FAIL wrap_full cyc%0d: got %b want %b", cyc, full, mq.size() == N); end
      if (mq.size() != 0 && ack) begin
        got++;
        n_vec++; if (pout !== W'(got)) begin n_err++; $display("FAIL wrap_order: got %0d want %0d", pout, got); end
      end
      if (r && mq.size() < N) nxt++;
      tick();
      cyc++;
    end
    r = 1'b0; ack = 1'b0; #1;
    n_vec++; if (got != 10) begin n_err++; $display("FAIL wrap_timeout: consumed %0d want 10", got); end
    n_vec++; if (cnt !== 3'd0) begin n_err++; $display("FAIL wrap_end_count: got %0d want 0", cnt); end
  endtask

  task automatic test_simul();
    r = 1'b1; pin = W'(7); tick(); r = 1'b0;
    n_vec++; if (cnt !== 3'd1) begin n_err++; $display("FAIL simul_setup1: got %0d want 1", cnt); end
    r = 1'b1; pin = W'(8); ack = 1'b1; #1;
    n_vec++; if (g !== 1'b1) begin n_err++; $display("FAIL simul_grant1: got %b want 1", g); end
    tick(); r = 1'b0; ack = 1'b0;
    n_vec++; if (cnt !== 3'd1) begin n_err++; $display("FAIL simul_count1: got %0d want 1", cnt); end
    n_vec++; if (vld !== 1'b1) begin n_err++; $display("FAIL simul_valid1: got %b want 1", vld); end
    n_vec++; if (pout !== W'(8)) begin n_err++; $display("FAIL simul_data1: got %0d want 8", pout); end
    r = 1'b1; pin = W'(9); tick();
    pin = W'(10); ack = 1'b1; tick(); r = 1'b0; ack = 1'b0;
    n_vec++; if (cnt !== 3'd2) begin n_err++; $display("FAIL simul_count2: got %0d want 2", cnt); end
    n_vec++; if (pout !== W'(9)) begin n_err++; $display("FAIL simul_data2: got %0d want 9", pout); end
    ack = 1'b1; tick();
    n_vec++; if (pout !== W'(10)) begin n_err++; $display("FAIL simul_data3: got %0d want 10", pout); end
    tick(); ack = 1'b0;
    n_vec++; if (cnt !== 3'd0) begin n_err++; $display("FAIL simul_drain: got %0d want 0", cnt); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp;
    r = 1'b1;
    for (int i = 0; i < N; i++) begin
      pin = rnd_pkt(); #1;
      n_vec++; if (g !== 1'b1) begin n_err++; $display("FAIL b2b_grant %0d: got %b want 1", i, g); end
      tick();
    end
    r = 1'b0; ack = 1'b1;
    for (int i = 0; i < N; i++) begin
      exp = mq[0];
      n_vec++; if (pout !== exp) begin n_err++; $display("FAIL b2b_data %0d: got %h want %h", i, pout, exp); end
      tick();
    end
    ack = 1'b0;
    n_vec++; if (vld !== 1'b0) begin n_err++; $display("FAIL b2b_empty: got %b want 0", vld); end
  endtask

  task automatic test_reset_mid();
    r = 1'b1;
    for (int i = 0; i < 3; i++) begin pin = rnd_pkt(); tick(); end
    r = 1'b0;
    n_vec++; if (cnt !== 3'd3) begin n_err++; $display("FAIL rmid_setup: got %0d want 3", cnt); end
    rst = 1'b1; r = 1'b1; ack = 1'b1; pin = rnd_pkt(); #1;
    n_vec++; if (g !== 1'b0) begin n_err++; $display("FAIL rmid_grant: got %b want 0", g); end
    tick(); rst = 1'b0; r = 1'b0; ack = 1'b0;
    n_vec++; if (cnt !== 3'd0) begin n_err++; $display("FAIL rmid_count: got %0d want 0", cnt); end
    n_vec++; if (vld !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b want 0", vld); end
    ack = 1'b1; tick(); ack = 1'b0;
    n_vec++; if (cnt !== 3'd0) begin n_err++; $display("FAIL rmid_empty_ack: got %0d want 0", cnt); end
    r = 1'b1; pin = rnd_pkt(); tick(); r = 1'b0;
    n_vec++; if (pout !== mq[0] || cnt !== 3'd1) begin n_err++; $display("FAIL rmid_restart: got %h/%0d want %h/1", pout, cnt, mq[0]); end
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_wrap();
    test_simul();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/packet_queue.md
# packet_queue

Receive-side packet queue between the NIC's flit-reassembly stage and the message (WISHBONE-side) logic. Accepts whole reassembled packets over the request/grant handshake driven by the flit buffer and stores up to N_PACKETS of them in FIFO order. Presents the oldest packet to the message stage with a valid/ack handshake, so the flit buffer is freed as soon as space exists rather than when the bus side is ready.

## Interface
- PKT_WIDTH, default `MAX_PACKET_LENGHT*`FLIT_WIDTH: width of one packet; flit 0 (head/head_tail) occupies bits [FLIT_WIDTH-1:0], flit i the next slice up.
- N_PACKETS, default 4: queue depth in packets; must be a power of two, ≥2.
- N_BITS_PTR, default 2: log2(N_PACKETS).
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- r_pkt_to_msg_i  in  1  upstream request: a complete packet is on in_pkt_i.
- in_pkt_i  in  PKT_WIDTH  packet from upstream; sampled only on an accepting edge.
- g_pkt_to_msg_o  out  1  grant: packet is captured at this clock edge.
- msg_valid_o  out  1  out_msg_o holds the oldest stored packet.
- out_msg_o  out  PKT_WIDTH  oldest stored packet.
- msg_ack_i  in  1  downstream consumed out_msg_o this cycle.
- count_o  out  N_BITS_PTR+1  number of stored packets, 0..N_PACKETS.
- full_o  out  1  count_o == N_PACKETS.

## Operation
- Storage: N_PACKETS×PKT_WIDTH register array, write pointer wr_ptr, read pointer rd_ptr (N_BITS_PTR bits each, natural wrap N_PACKETS-1→0), counter cnt (N_BITS_PTR+1 bits).
- Grant: g_pkt_to_msg_o = r_pkt_to_msg_i & !full_o & !rst. Combinational from request; no dependency on msg_ack_i (a pop in the same cycle does not free space for a push while full).
- Push: on an edge with r_pkt_to_msg_i & g_pkt_to_msg_o: mem[wr_ptr] <= in_pkt_i, wr_ptr++.
- Pop: on an edge with msg_valid_o & msg_ack_i: rd_ptr++. msg_ack_i while msg_valid_o=0 is ignored.
- Count: push only → +1; pop only → −1; both → unchanged; neither → unchanged. Never exceeds N_PACKETS nor goes below 0.
- Outputs: msg_valid_o = (cnt != 0); out_msg_o = mem[rd_ptr] (direct register read, no extra stage); count_o = cnt; full_o = (cnt == N_PACKETS).
- Storage array is not reset; out_msg_o is don't-care while msg_valid_o=0.
- Reset: wr_ptr, rd_ptr, cnt ← 0. rst has priority over a push and a pop in the same cycle; both are discarded.
- Reset mid-operation: all stored packets are dropped; the upstream flit buffer is reset by the same rst.

## Timing
- Reset values: msg_valid_o=0, count_o=0, full_o=0, g_pkt_to_msg_o=0 while rst=1 (then follows r_pkt_to_msg_i).
- Push-to-present latency: packet granted at edge k is on out_msg_o with msg_valid_o=1 in cycle k+1 when the queue was empty.
- Pop: next packet (if any) appears on out_msg_o the cycle after the acking edge; msg_valid_o drops the cycle after acking the last packet.
- Full release: ack at edge k with full_o=1 → full_o=0 and grant possible in cycle k+1.
- Push and pop at cnt=1 on the same edge: msg_valid_o stays 1, next cycle shows the new packet.
- Back-to-back pushes: one packet per cycle while not full; back-to-back pops: one per cycle.

## Test plan
- Reset: hold rst=1 with r_pkt_to_msg_i=1 for 3 cycles → g=0 throughout, then msg_valid_o=0, count_o=0, full_o=0.
- Single packet (PKT_WIDTH=128): r=1, in_pkt_i=128'h0000_0004_0000_0003_0000_0002_0000_0001 → g=1 same cycle; next cycle msg_valid_o=1, out_msg_o equals it, count_o=1; ack one cycle → next cycle msg_valid_o=0, count_o=0.
- Fill: 4 pushes (values 1..4), no ack → full_o=1, count_o=4; 5th request held → g=0 for 3 cycles; ack once → out_msg_o=2 and g=1 next cycle, 5th packet accepted, count_o=4.
- Wrap/order: stream packets 1..10 with random ack gaps → consumed in order 1..10, count_o never >4, ends at 0.
- Simultaneous push/pop: at count_o=1 (holding 7) push 8 while acking → count_o stays 1, out_msg_o=8 next cycle; at count_o=2 same → count_o stays 2.
- Reset mid-operation with count_o=3, concurrent push and ack → next cycle count_o=0, msg_valid_o=0; ack while empty → count_o stays 0.
